fwd_hazard_sb_unit: RTL and testbench

Parametrised forwarding and hazard unit for the RV32 in-order core, generalising the two-port EXE/MEM forwarder.
- Supports N read ports and M forwarding stages, with per-stage data-valid qualification; this covers load-use and any late-result stage.
- Adds a register scoreboard for variable-latency long ops (divider, cache-miss load), with completion bypass and RAW/WAW/structural stall generation.
- Sits beside ID: feeds forwarded operands to ID and the stall request to the hazard detection unit (HDU).

---
 rtl/fwd_hazard_sb_unit.sv | 176 +++++++++++++++++
 tb/tb_fwd_hazard_sb_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_sb_unit.sv
// rtl/fwd_hazard_sb_unit.sv - N-port operand forwarding, long-op scoreboard and ID stall generation
// Optional: define FWD_PERF_CNT_EN to build the saturating stall-cycle counters.
module fwd_hazard_sb_unit #(
    parameter int NUM_RD_PORTS  = 2,
    parameter int NUM_FW_STAGES = 3,
    parameter int XLEN          = 32,
    parameter int RADDR_W       = 5,
    parameter int LO_MAX_OUT    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_RD_PORTS*RADDR_W-1:0]   rd_raddr_i,
    input  logic [NUM_RD_PORTS-1:0]           rd_re_i,
    input  logic [RADDR_W-1:0]                id_rd_i,
    input  logic                              id_we_i,
    input  logic [NUM_FW_STAGES*RADDR_W-1:0]  st_waddr_i,
    input  logic [NUM_FW_STAGES-1:0]          st_we_i,
    input  logic [NUM_FW_STAGES-1:0]          st_dvalid_i,
    input  logic [NUM_FW_STAGES*XLEN-1:0]     st_wdata_i,
    input  logic                              lo_issue_i,
    input  logic                              lo_cpl_i,
    input  logic [RADDR_W-1:0]                lo_cpl_rd_i,
    input  logic [XLEN-1:0]                   lo_cpl_data_i,
    input  logic                              flush_i,
    output logic [NUM_RD_PORTS-1:0]           fw_en_o,
    output logic [NUM_RD_PORTS*XLEN-1:0]      fw_data_o,
    output logic                              stall_o,
    output logic                              stall_raw_o,
    output logic                              stall_waw_o,
    output logic                              stall_struct_o,
    output logic [2**RADDR_W-1:0]             pending_o,
    output logic [$clog2(LO_MAX_OUT+1)-1:0]   lo_cnt_o,
    output logic                              sb_err_o,
    output logic [31:0]                       perf_raw_cnt_o,
    output logic [31:0]                       perf_waw_cnt_o,
    output logic [31:0]                       perf_struct_cnt_o
);

    localparam int NREGS = 2**RADDR_W;
    localparam int CNT_W = $clog2(LO_MAX_OUT+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LO_MAX_OUT);

    logic [NREGS-1:0]        pending_q;
    logic [NREGS-1:0]        pending_nxt;
    logic [CNT_W-1:0]        lo_cnt_q;
    logic                    sb_err_q;
    logic [NUM_RD_PORTS-1:0] port_raw;
    logic                    raw_c;
    logic                    waw_c;
    logic                    struct_c;
    logic                    cpl_valid;
    logic                    issue_fire;

    // Per-port operand resolution: youngest matching stage wins, scoreboard only if no stage matches.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [RADDR_W-1:0] raddr;
        logic               hit;
        logic               en;
        logic               raw;
        logic [XLEN-1:0]    data;

        assign raddr = rd_raddr_i[p*RADDR_W +: RADDR_W];

        always_comb begin
            hit  = 1'b0;
            en   = 1'b0;
            raw  = 1'b0;
            data = '0;
            if (rd_re_i[p] && (raddr != '0)) begin
                for (int s = 0; s < NUM_FW_STAGES; s++) begin
                    if (!hit && st_we_i[s] && (st_waddr_i[s*RADDR_W +: RADDR_W] == raddr)) begin
                        hit = 1'b1;
                        if (st_dvalid_i[s]) begin
                            en   = 1'b1;
                            data = st_wdata_i[s*XLEN +: XLEN];
                        end else begin
                            raw = 1'b1;
                        end
                    end
                end
                if (!hit && pending_q[raddr]) begin
                    if (lo_cpl_i && (lo_cpl_rd_i == raddr)) begin
                        en   = 1'b1;
                        data = lo_cpl_data_i;
                    end else begin
                        raw = 1'b1;
                    end
                end
            end
        end

        assign fw_en_o[p]                 = en;
        assign fw_data_o[p*XLEN +: XLEN]  = data;
        assign port_raw[p]                = raw;
    end

    assign raw_c    = |port_raw;
    assign waw_c    = id_we_i && (id_rd_i != '0) && pending_q[id_rd_i]
                      && !(lo_cpl_i && (lo_cpl_rd_i == id_rd_i));
    assign struct_c = lo_issue_i && (lo_cnt_q == CNT_MAX) && !lo_cpl_i;

    assign stall_raw_o    = raw_c    && !flush_i;
    assign stall_waw_o    = waw_c    && !flush_i;
    assign stall_struct_o = struct_c && !flush_i;
    assign stall_o        = stall_raw_o || stall_waw_o || stall_struct_o;

    assign issue_fire = lo_issue_i && !flush_i && !stall_o && (id_rd_i != '0);
    assign cpl_valid  = lo_cpl_i && (lo_cpl_rd_i != '0) && pending_q[lo_cpl_rd_i];

    // Clear before set so an issue and completion to the same register leaves it pending.
    always_comb begin
        pending_nxt = pending_q;
        if (cpl_valid) begin
            pending_nxt[lo_cpl_rd_i] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[id_rd_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            lo_cnt_q  <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_nxt;
            if (issue_fire && !cpl_valid && (lo_cnt_q != CNT_MAX)) begin
                lo_cnt_q <= lo_cnt_q + 1'b1;
            end else if (!issue_fire && cpl_valid && (lo_cnt_q != '0)) begin
                lo_cnt_q <= lo_cnt_q - 1'b1;
            end
            if (lo_cpl_i && !cpl_valid) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign pending_o = pending_q;
    assign lo_cnt_o  = lo_cnt_q;
    assign sb_err_o  = sb_err_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_raw_q;
    logic [31:0] perf_waw_q;
    logic [31:0] perf_struct_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_raw_q    <= '0;
            perf_waw_q    <= '0;
            perf_struct_q <= '0;
        end else begin
            if (stall_raw_o && (perf_raw_q != 32'hFFFF_FFFF)) begin
                perf_raw_q <= perf_raw_q + 32'd1;
            end
            if (stall_waw_o && (perf_waw_q != 32'hFFFF_FFFF)) begin
                perf_waw_q <= perf_waw_q + 32'd1;
            end
            if (stall_struct_o && (perf_struct_q != 32'hFFFF_FFFF)) begin
                perf_struct_q <= perf_struct_q + 32'd1;
            end
        end
    end

    assign perf_raw_cnt_o    = perf_raw_q;
    assign perf_waw_cnt_o    = perf_waw_q;
    assign perf_struct_cnt_o = perf_struct_q;
`else
    assign perf_raw_cnt_o    = '0;
    assign perf_waw_cnt_o    = '0;
    assign perf_struct_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_sb_unit.sv
// tb/tb_fwd_hazard_sb_unit.sv - directed self-checking bench for fwd_hazard_sb_unit
module tb_fwd_hazard_sb_unit;

    localparam int NP = 2;
    localparam int NS = 3;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int LM = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*RW-1:0]  rd_raddr_i;
    logic [NP-1:0]     rd_re_i;
    logic [RW-1:0]     id_rd_i;
    logic              id_we_i;
    logic [NS*RW-1:0]  st_waddr_i;
    logic [NS-1:0]     st_we_i;
    logic [NS-1:0]     st_dvalid_i;
    logic [NS*XL-1:0]  st_wdata_i;
    logic              lo_issue_i;
    logic              lo_cpl_i;
    logic [RW-1:0]     lo_cpl_rd_i;
    logic [XL-1:0]     lo_cpl_data_i;
    logic              flush_i;
    logic [NP-1:0]     fw_en_o;
    logic [NP*XL-1:0]  fw_data_o;
    logic              stall_o;
    logic              stall_raw_o;
    logic              stall_waw_o;
    logic              stall_struct_o;
    logic [31:0]       pending_o;
    logic [2:0]        lo_cnt_o;
    logic              sb_err_o;
    logic [31:0]       perf_raw_cnt_o;
    logic [31:0]       perf_waw_cnt_o;
    logic [31:0]       perf_struct_cnt_o;

    int total  = 0;
    int passed = 0;

    fwd_hazard_sb_unit #(
        .NUM_RD_PORTS(NP), .NUM_FW_STAGES(NS), .XLEN(XL), .RADDR_W(RW), .LO_MAX_OUT(LM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_raddr_i(rd_raddr_i), .rd_re_i(rd_re_i),
        .id_rd_i(id_rd_i), .id_we_i(id_we_i),
        .st_waddr_i(st_waddr_i), .st_we_i(st_we_i), .st_dvalid_i(st_dvalid_i), .st_wdata_i(st_wdata_i),
        .lo_issue_i(lo_issue_i), .lo_cpl_i(lo_cpl_i), .lo_cpl_rd_i(lo_cpl_rd_i), .lo_cpl_data_i(lo_cpl_data_i),
        .flush_i(flush_i),
        .fw_en_o(fw_en_o), .fw_data_o(fw_data_o),
        .stall_o(stall_o), .stall_raw_o(stall_raw_o), .stall_waw_o(stall_waw_o), .stall_struct_o(stall_struct_o),
        .pending_o(pending_o), .lo_cnt_o(lo_cnt_o), .sb_err_o(sb_err_o),
        .perf_raw_cnt_o(perf_raw_cnt_o), .perf_waw_cnt_o(perf_waw_cnt_o), .perf_struct_cnt_o(perf_struct_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rd_raddr_i    = '0;
        rd_re_i       = '0;
        id_rd_i       = '0;
        id_we_i       = 1'b0;
        st_waddr_i    = '0;
        st_we_i       = '0;
        st_dvalid_i   = '0;
        st_wdata_i    = '0;
        lo_issue_i    = 1'b0;
        lo_cpl_i      = 1'b0;
        lo_cpl_rd_i   = '0;
        lo_cpl_data_i = '0;
        flush_i       = 1'b0;
    endtask

    task automatic set_stage(input int s, input logic we, input logic [RW-1:0] a,
                             input logic dv, input logic [XL-1:0] d);
        st_we_i[s]              = we;
        st_waddr_i[s*RW +: RW]  = a;
        st_dvalid_i[s]          = dv;
        st_wdata_i[s*XL +: XL]  = d;
    endtask

    task automatic set_port(input int p, input logic re, input logic [RW-1:0] a);
        rd_re_i[p]              = re;
        rd_raddr_i[p*RW +: RW]  = a;
    endtask

    task automatic issue(input logic [RW-1:0] r);
        id_rd_i    = r;
        id_we_i    = 1'b1;
        lo_issue_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        total++; if (pending_o !== 32'h0) $display("FAIL rst_pending got %h exp 0", pending_o); else passed++;
        total++; if (lo_cnt_o !== 3'd0) $display("FAIL rst_lo_cnt got %0d exp 0", lo_cnt_o); else passed++;
        total++; if (sb_err_o !== 1'b0) $display("FAIL rst_sb_err got %b exp 0", sb_err_o); else passed++;
        total++; if (perf_raw_cnt_o !== 32'd0) $display("FAIL rst_perf_raw got %0d exp 0", perf_raw_cnt_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall_o); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_long_op();
        @(negedge clk); clear_inputs(); issue(5'd9); #1;
        total++; if (stall_o !== 1'b0) $display("FAIL lo_issue_stall got %b exp 0", stall_o); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clear_inputs(); set_port(0, 1'b1, 5'd9); #1;
            total++; if (stall_raw_o !== 1'b1) $display("FAIL lo_raw_%0d got %b exp 1", i, stall_raw_o); else passed++;
            total++; if (fw_en_o !== 2'b00) $display("FAIL lo_fw_en_%0d got %b exp 00", i, fw_en_o); else passed++;
            if (i == 0) begin
                total++; if (pending_o !== 32'h0000_0200) $display("FAIL lo_pending got %h exp 00000200", pending_o); else passed++;
                total++; if (lo_cnt_o !== 3'd1) $display("FAIL lo_cnt_one got %0d exp 1", lo_cnt_o); else passed++;
            end
        end
        @(negedge clk); clear_inputs(); set_port(0, 1'b1, 5'd9);
        lo_cpl_i = 1'b1; lo_cpl_rd_i = 5'd9; lo_cpl_data_i = 32'hDEAD; #1;
        total++; if (fw_en_o !== 2'b01) $display("FAIL lo_bypass_en got %b exp 01", fw_en_o); else passed++;
        total++; if (fw_data_o[31:0] !== 32'hDEAD) $display("FAIL lo_bypass_data got %h exp 0000dead", fw_data_o[31:0]); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL lo_bypass_stall got %b exp 0", stall_o); else passed++;
        @(negedge clk); clear_inputs(); #1;
        total++; if (pending_o !== 32'h0) $display("FAIL lo_cleared got %h exp 0", pending_o); else passed++;
        total++; if (lo_cnt_o !== 3'd0) $display("FAIL lo_cnt_zero got %0d exp 0", lo_cnt_o); else passed++;
`ifdef FWD_PERF_CNT_EN
        total++; if (perf_raw_cnt_o !== 32'd3) $display("FAIL perf_raw got %0d exp 3", perf_raw_cnt_o); else passed++;
`else
        total++; if (perf_raw_cnt_o !== 32'd0) $display("FAIL perf_raw_off got %0d exp 0", perf_raw_cnt_o); else passed++;
`endif
        total++; if (perf_waw_cnt_o !== 32'd0) $display("FAIL perf_waw got %0d exp 0", perf_waw_cnt_o); else passed++;
    endtask

    task automatic test_priority();
        @(negedge clk); clear_inputs();
        set_port(0, 1'b1, 5'd5);
        set_stage(0, 1'b1, 5'd5, 1'b1, 32'hAAAA);
        set_stage(1, 1'b1, 5'd5, 1'b1, 32'hBBBB);
        #1;
        total++; if (fw_en_o !== 2'b01) $display("FAIL prio_en got %b exp 01", fw_en_o); else passed++;
        total++; if (fw_data_o[31:0] !== 32'hAAAA) $display("FAIL prio_data got %h exp 0000aaaa", fw_data_o[31:0]); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL prio_stall got %b exp 0", stall_o); else passed++;
        set_port(0, 1'b1, 5'd0);
        set_stage(0, 1'b1, 5'd0, 1'b1, 32'h5555);
        #1;
        total++; if (fw_en_o !== 2'b00) $display("FAIL x0_en got %b exp 00", fw_en_o); else passed++;
        total++; if (fw_data_o !== 64'h0) $display("FAIL x0_data got %h exp 0", fw_data_o); else passed++;
    endtask

    task automatic test_load_use();
        @(negedge clk); clear_inputs();
        set_port(1, 1'b1, 5'd7);
        set_stage(0, 1'b1, 5'd7, 1'b0, 32'hFFFF);
        set_stage(1, 1'b1, 5'd7, 1'b1, 32'h9999);
        #1;
        total++; if (stall_raw_o !== 1'b1) $display("FAIL lu_raw got %b exp 1", stall_raw_o); else passed++;
        total++; if (fw_en_o !== 2'b00) $display("FAIL lu_en got %b exp 00", fw_en_o); else passed++;
        @(negedge clk); clear_inputs();
        set_port(1, 1'b1, 5'd7);
        set_stage(1, 1'b1, 5'd7, 1'b1, 32'h1234);
        #1;
        total++; if (fw_en_o !== 2'b10) $display("FAIL lu_fw_en got %b exp 10", fw_en_o); else passed++;
        total++; if (fw_data_o[63:32] !== 32'h1234) $display("FAIL lu_fw_data got %h exp 00001234", fw_data_o[63:32]); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL lu_stall got %b exp 0", stall_o); else passed++;
    endtask

    task automatic test_waw_struct();
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk); clear_inputs(); issue(5'(r)); #1;
            total++; if (stall_o !== 1'b0) $display("FAIL ws_issue_%0d got %b exp 0", r, stall_o); else passed++;
        end
        @(negedge clk); clear_inputs(); #1;
        total++; if (lo_cnt_o !== 3'd4) $display("FAIL ws_cnt4 got %0d exp 4", lo_cnt_o); else passed++;
        total++; if (pending_o !== 32'h0000_001E) $display("FAIL ws_pending got %h exp 0000001e", pending_o); else passed++;
        @(negedge clk); clear_inputs(); issue(5'd5); #1;
        total++; if (stall_struct_o !== 1'b1) $display("FAIL ws_struct got %b exp 1", stall_struct_o); else passed++;
        total++; if (stall_o !== 1'b1) $display("FAIL ws_struct_stall got %b exp 1", stall_o); else passed++;
        @(negedge clk); clear_inputs(); id_we_i = 1'b1; id_rd_i = 5'd2; #1;
        total++; if (stall_waw_o !== 1'b1) $display("FAIL ws_waw got %b exp 1", stall_waw_o); else passed++;
        total++; if (stall_struct_o !== 1'b0) $display("FAIL ws_waw_nostruct got %b exp 0", stall_struct_o); else passed++;
        total++; if (pending_o !== 32'h0000_001E) $display("FAIL ws_no_x5 got %h exp 0000001e", pending_o); else passed++;
        @(negedge clk); clear_inputs(); issue(5'd2);
        lo_cpl_i = 1'b1; lo_cpl_rd_i = 5'd2; lo_cpl_data_i = 32'h22; #1;
        total++; if (stall_o !== 1'b0) $display("FAIL ws_cpl_issue_stall got %b exp 0", stall_o); else passed++;
        @(negedge clk); clear_inputs(); #1;
        total++; if (pending_o !== 32'h0000_001E) $display("FAIL ws_set_wins got %h exp 0000001e", pending_o); else passed++;
        total++; if (lo_cnt_o !== 3'd4) $display("FAIL ws_cnt_hold got %0d exp 4", lo_cnt_o); else passed++;
    endtask

    task automatic test_err_flush_reset();
        @(negedge clk); clear_inputs(); lo_cpl_i = 1'b1; lo_cpl_rd_i = 5'd10; #1;
        @(negedge clk); clear_inputs(); #1;
        total++; if (sb_err_o !== 1'b1) $display("FAIL err_set got %b exp 1", sb_err_o); else passed++;
        total++; if (lo_cnt_o !== 3'd4) $display("FAIL err_cnt got %0d exp 4", lo_cnt_o); else passed++;
        set_port(0, 1'b1, 5'd1); #1;
        total++; if (stall_raw_o !== 1'b1) $display("FAIL fl_pre_raw got %b exp 1", stall_raw_o); else passed++;
        flush_i = 1'b1; issue(5'd6); #1;
        total++; if (stall_o !== 1'b0) $display("FAIL fl_stall got %b exp 0", stall_o); else passed++;
        total++; if (stall_raw_o !== 1'b0) $display("FAIL fl_raw got %b exp 0", stall_raw_o); else passed++;
        @(negedge clk); clear_inputs(); #1;
        total++; if (pending_o !== 32'h0000_001E) $display("FAIL fl_no_issue got %h exp 0000001e", pending_o); else passed++;
        #2 rst_n = 1'b0; #1;
        total++; if (pending_o !== 32'h0) $display("FAIL mid_rst_pending got %h exp 0", pending_o); else passed++;
        total++; if (lo_cnt_o !== 3'd0) $display("FAIL mid_rst_cnt got %0d exp 0", lo_cnt_o); else passed++;
        total++; if (sb_err_o !== 1'b0) $display("FAIL mid_rst_err got %b exp 0", sb_err_o); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); clear_inputs(); lo_cpl_i = 1'b1; lo_cpl_rd_i = 5'd3; #1;
        @(negedge clk); clear_inputs(); #1;
        total++; if (sb_err_o !== 1'b1) $display("FAIL late_cpl_err got %b exp 1", sb_err_o); else passed++;
        total++; if (lo_cnt_o !== 3'd0) $display("FAIL late_cpl_cnt got %0d exp 0", lo_cnt_o); else passed++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_long_op();
        test_priority();
        test_load_use();
        test_waw_struct();
        test_err_flush_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
